// File: rtl/rv32i_multicycle_core_if.sv
// Unified instruction/data memory port: req/ready handshake, any wait-state count.
interface rv32i_multicycle_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/rv32i_multicycle_core.sv
// Multi-cycle RV32I/RV32E core: FETCH/DECODE/EXECUTE/MEM/WB over one shared memory port.
module rv32i_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  rv32i_multicycle_core_if.master        bus,
  output logic                           halted,
  output logic [1:0]                     trap_cause,
  output logic [31:0]                    pc_out
);
  localparam int RW = $clog2(NUM_REGS);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                         OP_FENCE = 7'b0001111;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_alu, r_npc, r_mdr;
  logic [31:0] r_regs [NUM_REGS];
  logic        r_req, r_we, r_halted;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_cause;

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wstrb = r_wstrb;
  assign halted        = r_halted;
  assign trap_cause    = r_cause;
  assign pc_out        = r_pc;

  logic [6:0] w_op, w_f7;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic [2:0] w_f3;
  logic       w_rd_bad, w_rs1_bad, w_rs2_bad, w_is_ld, w_is_st, w_wr_rd;
  assign w_op      = r_ir[6:0];
  assign w_rd      = r_ir[11:7];
  assign w_f3      = r_ir[14:12];
  assign w_rs1     = r_ir[19:15];
  assign w_rs2     = r_ir[24:20];
  assign w_f7      = r_ir[31:25];
  assign w_rd_bad  = {27'b0, w_rd}  >= NUM_REGS;
  assign w_rs1_bad = {27'b0, w_rs1} >= NUM_REGS;
  assign w_rs2_bad = {27'b0, w_rs2} >= NUM_REGS;
  assign w_is_ld   = (w_op == OP_LD);
  assign w_is_st   = (w_op == OP_ST);
  assign w_wr_rd   = (w_op == OP_LUI) | (w_op == OP_AUIPC) | (w_op == OP_JAL) | (w_op == OP_JALR) |
                     w_is_ld | (w_op == OP_IMM) | (w_op == OP_REG);

  logic [31:0] w_imm;
  logic        w_illegal;
  // Immediate formation and illegal-encoding detection from the latched IR.
  always_comb begin
    w_imm     = {{20{r_ir[31]}}, r_ir[31:20]};
    w_illegal = 1'b0;
    case (w_op)
      OP_LUI, OP_AUIPC: begin w_imm = {r_ir[31:12], 12'b0}; w_illegal = w_rd_bad; end
      OP_JAL: begin
        w_imm     = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
        w_illegal = w_rd_bad;
      end
      OP_JALR: w_illegal = (w_f3 != 3'b000) | w_rd_bad | w_rs1_bad;
      OP_BR: begin
        w_imm     = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        w_illegal = (w_f3[2:1] == 2'b01) | w_rs1_bad | w_rs2_bad;
      end
      OP_LD: w_illegal = (w_f3 == 3'b011) | (w_f3[2:1] == 2'b11) | w_rd_bad | w_rs1_bad;
      OP_ST: begin
        w_imm     = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        w_illegal = w_f3[2] | (w_f3[1:0] == 2'b11) | w_rs1_bad | w_rs2_bad;
      end
      OP_IMM: w_illegal = ((w_f3 == 3'b001) & (w_f7 != 7'b0)) |
                          ((w_f3 == 3'b101) & (w_f7 != 7'b0) & (w_f7 != 7'b0100000)) |
                          w_rd_bad | w_rs1_bad;
      OP_REG: w_illegal = ((w_f7 != 7'b0) &
                           !((w_f7 == 7'b0100000) & ((w_f3 == 3'b000) | (w_f3 == 3'b101)))) |
                          w_rd_bad | w_rs1_bad | w_rs2_bad;
      OP_FENCE: w_illegal = (w_f3 != 3'b000);
      default:  w_illegal = 1'b1;
    endcase
  end

  logic [31:0] w_opb, w_alu, w_res, w_npc, w_pc4, w_ea, w_sdata, w_lsh, w_ld;
  logic [4:0]  w_sh;
  logic [3:0]  w_sstrb;
  logic        w_take, w_mis;
  // ALU, branch compare, next-PC, effective address and store/load lane steering.
  always_comb begin
    w_opb = (w_op == OP_REG) ? r_b : r_imm;
    w_sh  = w_opb[4:0];
    case (w_f3)
      3'b000:  w_alu = ((w_op == OP_REG) & r_ir[30]) ? r_a - w_opb : r_a + w_opb;
      3'b001:  w_alu = r_a << w_sh;
      3'b010:  w_alu = {31'b0, $signed(r_a) < $signed(w_opb)};
      3'b011:  w_alu = {31'b0, r_a < w_opb};
      3'b100:  w_alu = r_a ^ w_opb;
      3'b101:  w_alu = r_ir[30] ? 32'($signed(r_a) >>> w_sh) : r_a >> w_sh;
      3'b110:  w_alu = r_a | w_opb;
      default: w_alu = r_a & w_opb;
    endcase
    case (w_f3)
      3'b000:  w_take = (r_a == r_b);
      3'b001:  w_take = (r_a != r_b);
      3'b100:  w_take = $signed(r_a) <  $signed(r_b);
      3'b101:  w_take = $signed(r_a) >= $signed(r_b);
      3'b110:  w_take = r_a <  r_b;
      3'b111:  w_take = r_a >= r_b;
      default: w_take = 1'b0;
    endcase
    w_pc4 = r_pc + 32'd4;
    w_ea  = r_a + r_imm;
    w_res = w_alu;
    w_npc = w_pc4;
    case (w_op)
      OP_LUI:   w_res = r_imm;
      OP_AUIPC: w_res = r_pc + r_imm;
      OP_JAL:   begin w_res = w_pc4; w_npc = r_pc + r_imm; end
      OP_JALR:  begin w_res = w_pc4; w_npc = w_ea & ~32'd1; end
      OP_BR:    if (w_take) w_npc = r_pc + r_imm;
      default:  ;
    endcase
    w_mis = ((w_f3[1:0] == 2'b01) & w_ea[0]) | ((w_f3[1:0] == 2'b10) & (w_ea[1:0] != 2'b00));
    case (w_f3[1:0])
      2'b00:   begin w_sdata = {4{r_b[7:0]}};  w_sstrb = 4'b0001 << w_ea[1:0]; end
      2'b01:   begin w_sdata = {2{r_b[15:0]}}; w_sstrb = w_ea[1] ? 4'b1100 : 4'b0011; end
      default: begin w_sdata = r_b;            w_sstrb = 4'b1111; end
    endcase
    // r_alu holds the EA while in MEM, so its low bits pick the load lane.
    w_lsh = bus.mem_rdata >> {r_alu[1:0], 3'b000};
    case (w_f3)
      3'b000:  w_ld = {{24{w_lsh[7]}}, w_lsh[7:0]};
      3'b001:  w_ld = {{16{w_lsh[15]}}, w_lsh[15:0]};
      3'b100:  w_ld = {24'b0, w_lsh[7:0]};
      3'b101:  w_ld = {16'b0, w_lsh[15:0]};
      default: w_ld = w_lsh;
    endcase
  end

  // Main FSM; bus outputs are registered and set up on the edge entering each request state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0; r_a <= '0; r_b <= '0; r_imm <= '0;
      r_alu    <= '0; r_npc <= '0; r_mdr <= '0;
      r_req    <= 1'b0; r_we <= 1'b0; r_addr <= RESET_PC;
      r_wdata  <= '0; r_wstrb <= '0;
      r_halted <= 1'b0; r_cause <= 2'd0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH:
          if (!r_req) begin
            // Only reached straight out of reset; WB normally raises the fetch request.
            r_req <= 1'b1; r_addr <= r_pc; r_we <= 1'b0; r_wstrb <= '0;
          end else if (bus.mem_ready) begin
            r_ir <= bus.mem_rdata; r_req <= 1'b0; r_state <= S_DECODE;
          end
        S_DECODE: begin
          r_a   <= r_regs[w_rs1[RW-1:0]];
          r_b   <= r_regs[w_rs2[RW-1:0]];
          r_imm <= w_imm;
          if (w_illegal) begin
            r_state <= S_HALT; r_halted <= 1'b1; r_cause <= 2'd1;
          end else r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_npc <= w_npc;
          if (w_is_ld | w_is_st) begin
            r_alu <= w_ea;
            if (w_mis) begin
              r_state <= S_HALT; r_halted <= 1'b1; r_cause <= 2'd2;
            end else begin
              r_state <= S_MEM; r_req <= 1'b1; r_addr <= w_ea; r_we <= w_is_st;
              r_wdata <= w_sdata; r_wstrb <= w_is_st ? w_sstrb : 4'b0000;
            end
          end else begin
            r_alu <= w_res;
            if (w_npc[1:0] != 2'b00) begin
              r_state <= S_HALT; r_halted <= 1'b1; r_cause <= 2'd3;
            end else r_state <= S_WB;
          end
        end
        S_MEM:
          if (bus.mem_ready) begin
            r_mdr <= w_ld; r_req <= 1'b0; r_we <= 1'b0; r_wstrb <= '0; r_state <= S_WB;
          end
        S_WB: begin
          if (w_wr_rd && (w_rd != 5'd0)) r_regs[w_rd[RW-1:0]] <= w_is_ld ? r_mdr : r_alu;
          r_pc <= r_npc; r_req <= 1'b1; r_addr <= r_npc; r_we <= 1'b0; r_wstrb <= '0;
          r_state <= S_FETCH;
        end
        S_HALT: ;
        default: r_state <= S_HALT;
      endcase
    end
  end
endmodule

// File: doc/rv32i_multicycle_core.md
# rv32i_multicycle_core

Multi-cycle RV32I integer core replacing the single-cycle datapath: one instruction moves through FETCH, DECODE, EXECUTE, MEM and WB states and shares a single memory port. The memory port uses a req/ready handshake that tolerates any wait-state count. The register count is parametrised (32 for RV32I, 16 for RV32E). The core sits between the top-level `clock` and `reset` and a unified instruction/data memory or bus bridge.

## Interface

Parameters:
- `RESET_PC`, `32'h0000_0000`: PC value loaded on reset; must be 4-aligned.
- `NUM_REGS`, `32`: architectural register count; legal values are 32 and 16.

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `mem_req` output 1: memory request valid.
- `mem_we` output 1: 1 = store, 0 = fetch or load.
- `mem_addr` output 32: byte address, always naturally aligned for its access size.
- `mem_wdata` output 32: store data, lane-replicated.
- `mem_wstrb` output 4: byte enables; 4'b0000 on reads.
- `mem_ready` input 1: completes the request in the cycle it is seen with `mem_req`=1.
- `mem_rdata` input 32: read data; valid in the `mem_ready` cycle.
- `halted` output 1: core stopped on a trap; sticky until reset.
- `trap_cause` output 2: 0 none, 1 illegal instruction, 2 misaligned data access, 3 misaligned jump/branch target.
- `pc_out` output 32: PC of the instruction in flight (debug).

## Operation

- Register file:
  - `NUM_REGS` x 32 bits; x0 reads 0 and writes to it are dropped.
  - An rs1/rs2/rd index >= `NUM_REGS` is an illegal instruction.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM, all OP.
  - FENCE executes as a no-op.
  - Any other opcode, funct3 or funct7 combination traps as illegal (ECALL and EBREAK included).
- State FETCH:
  - Drive `mem_req`=1, `mem_addr`=PC, `mem_we`=0.
  - On `mem_ready`, latch IR and go to DECODE.
- State DECODE:
  - Read rs1/rs2 into the A/B latches.
  - Form the immediate for the I/S/B/U/J format, with sign extension from IR[31].
  - Detect illegal instructions and go to HALT if found; otherwise go to EXECUTE.
- State EXECUTE:
  - The ALU computes the result, effective address or target. Shift amounts use [4:0]. SLT/SLTU use signed/unsigned compare.
  - Branch compare happens in the same cycle.
  - Loads and stores go to MEM; everything else goes to WB.
  - A misaligned effective address goes to HALT with cause 2.
  - A taken branch, JAL or JALR with target[1:0]!=0 goes to HALT with cause 3. JALR clears bit 0 before this check.
- State MEM:
  - Issue the data request with `mem_addr`=EA.
  - SB/SH replicate data across lanes, and the strobe selects the lanes from EA[1:0].
  - On `mem_ready`, loads latch the extracted lane: sign-extended for LB/LH, zero-extended for LBU/LHU.
  - Then go to WB.
- State WB:
  - Write rd with the ALU result, load data, or PC+4 (JAL/JALR).
  - Update PC to the target (taken branch, JAL, JALR) or PC+4, wrapping modulo 2^32.
  - Go to FETCH.
- State HALT:
  - `mem_req`=0 and `halted`=1.
  - PC and registers are frozen, and `pc_out` holds the faulting PC.
  - Only reset leaves this state.

## Timing

- Reset values:
  - State FETCH, PC=`RESET_PC`, all registers 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=`RESET_PC`, `mem_wdata`=0, `mem_wstrb`=0.
  - `halted`=0, `trap_cause`=0, `pc_out`=`RESET_PC`.
- The first `mem_req` rises in the cycle after `reset` deasserts.
- Handshake rules:
  - While `mem_req`=1, `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` stay stable until the `mem_ready` cycle.
  - `mem_req` drops in the cycle after completion; there are no back-to-back requests.
  - `mem_ready` is ignored while `mem_req`=0.
- Latency with zero wait states (`mem_ready` high in the first request cycle):
  - ALU, branch and jump instructions: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - Loads and stores: 5 cycles.
  - Each wait state adds 1 cycle.
- Register write-back takes effect at the WB edge, so the next instruction's DECODE sees the new value. No forwarding is needed.
- Reset asserted mid-transaction:
  - The request is abandoned and `mem_req`=0 on the following cycle.
  - A store whose `mem_ready` coincides with the reset cycle counts as performed by memory; the core discards all state regardless.

## Test plan

- ALU arithmetic: reset with `RESET_PC`=0 and a zero-wait memory, program ADDI x1,x0,-5; ADDI x2,x0,3; SLT x3,x1,x2; SLTU x4,x1,x2 -> x1=0xFFFFFFFB, x3=1, x4=0. Each instruction takes exactly 4 cycles from `mem_req` to the next `mem_req`.
- Byte load/store lanes: SB of 0x80 to address 0x103 -> `mem_wstrb`=4'b1000, `mem_wdata`=0x80808080. LB back from 0x103 -> rd=0xFFFFFF80. LBU -> rd=0x00000080.
- Handshake under wait states: with 3 wait states on every access, the request fields stay stable for 4 cycles. LW completes in 11 cycles and the result is correct.
- Control flow: BNE taken, offset -8 at PC 0x20 -> next fetch at 0x18. JALR x1, x5, 3 with x5=0x100 -> PC=0x102 -> HALT, `trap_cause`=3. JAL at 0x40 -> x1=0x44.
- Traps and RV32E mode: LW from 0x102 -> `halted`=1, `trap_cause`=2, and no `mem_req` is issued after the fault. With `NUM_REGS`=16, ADD x17,x0,x0 -> `trap_cause`=1. ECALL -> `trap_cause`=1.
- Reset mid-operation: assert `reset` during MEM of an SW held with `mem_ready`=0 -> `mem_req`=0 the next cycle. After release, the first fetch goes to `RESET_PC`, x0–x31 read 0, and `halted`=0.
